// File: rtl/dly_ctrl_pkg.sv
// rtl/dly_ctrl_pkg.sv - shared state encoding and code field widths for delay-line blocks
package dly_ctrl_pkg;

  localparam int CODE_W   = 8;
  localparam int FINE_W   = 6;
  localparam int COARSE_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_LOCKED = 3'd3,
    ST_ERR    = 3'd4
  } state_e;

  // True when a step in direction dir would wrap the combined coarse/fine code.
  function automatic logic code_at_limit(input logic [CODE_W-1:0] code, input logic dir);
    logic [COARSE_W-1:0] coarse;
    logic [FINE_W-1:0]   fine;
    {coarse, fine} = code;
    return dir ? (&coarse && &fine) : (~|coarse && ~|fine);
  endfunction

endpackage

// File: rtl/dly_lock_ctrl_if.sv
// rtl/dly_lock_ctrl_if.sv - control, phase-detector and status bundle of the delay lock controller
interface dly_lock_ctrl_if #(
  parameter int CODE_W = dly_ctrl_pkg::CODE_W
);
  logic              i_start;
  logic              i_abort;
  logic              i_pd_vld;
  logic              i_pd_early;
  logic [CODE_W-1:0] o_dly_sel;
  logic              o_busy;
  logic              o_lock;
  logic              o_err;

  modport master (
    output i_start, i_abort, i_pd_vld, i_pd_early,
    input  o_dly_sel, o_busy, o_lock, o_err
  );

  modport slave (
    input  i_start, i_abort, i_pd_vld, i_pd_early,
    output o_dly_sel, o_busy, o_lock, o_err
  );
endinterface

// File: rtl/dly_settle_cnt.sv
// rtl/dly_settle_cnt.sv - loadable down-counter; done_o marks the last counted clock
module dly_settle_cnt #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         done_o
);
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign done_o = (cnt_q == W'(1));
endmodule

// File: rtl/dly_lock_ctrl.sv
// rtl/dly_lock_ctrl.sv - bang-bang lock loop stepping the delay select from phase-detector samples
// Optional DLY_LOCK_CTRL_TRACK_EN keeps stepping after lock instead of freezing the code.
module dly_lock_ctrl #(
  parameter int                CODE_W       = dly_ctrl_pkg::CODE_W,
  parameter logic [CODE_W-1:0] INIT_CODE    = '0,
  parameter int                SETTLE_CYC   = 16,
  parameter int                LOCK_TOGGLES = 4
) (
  input  logic           i_clk,
  input  logic           i_rstn,
  dly_lock_ctrl_if.slave bus
);
  import dly_ctrl_pkg::*;

  state_e            state_q;
  logic [CODE_W-1:0] code_q, code_d;
  logic              busy_q, lock_q, err_q;
  logic [3:0]        tog_q, tog_d;
  logic              pdir_q, pvld_q;
  logic              settle_done;
  logic              dir, sat, lock_hit;

  // The counter reloads whenever we are outside SETTLE, so each entry starts a full period.
  dly_settle_cnt #(.W(8)) u_settle (
    .clk_i      (i_clk),
    .rstn_i     (i_rstn),
    .load_i     (state_q != ST_SETTLE),
    .load_val_i (8'(SETTLE_CYC)),
    .en_i       (state_q == ST_SETTLE),
    .done_o     (settle_done)
  );

  always_comb begin
    dir      = bus.i_pd_early;
    tog_d    = tog_q;
    if (pvld_q && (dir != pdir_q) && (tog_q != 4'hF)) begin
      tog_d = tog_q + 4'd1;
    end
    lock_hit = !lock_q && (tog_d >= 4'(LOCK_TOGGLES));
    sat      = code_at_limit(code_q, dir);
    code_d   = dir ? code_q + CODE_W'(1) : code_q - CODE_W'(1);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= ST_IDLE;
      code_q  <= INIT_CODE;
      busy_q  <= 1'b0;
      lock_q  <= 1'b0;
      err_q   <= 1'b0;
      tog_q   <= '0;
      pdir_q  <= 1'b0;
      pvld_q  <= 1'b0;
    end else if (bus.i_abort) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      lock_q  <= 1'b0;
    end else if (bus.i_start && !busy_q) begin
      state_q <= ST_SETTLE;
      code_q  <= INIT_CODE;
      busy_q  <= 1'b1;
      lock_q  <= 1'b0;
      err_q   <= 1'b0;
      tog_q   <= '0;
      pvld_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_SETTLE: if (settle_done) state_q <= ST_SAMPLE;
        ST_SAMPLE: if (bus.i_pd_vld) begin
          tog_q  <= tog_d;
          pdir_q <= dir;
          pvld_q <= 1'b1;
          if (lock_hit) begin
            lock_q  <= 1'b1;
            busy_q  <= 1'b0;
`ifdef DLY_LOCK_CTRL_TRACK_EN
            state_q <= ST_SETTLE;
`else
            state_q <= ST_LOCKED;
`endif
          end else if (sat) begin
            state_q <= ST_ERR;
            err_q   <= 1'b1;
            lock_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            code_q  <= code_d;
            state_q <= ST_SETTLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_dly_sel = code_q;
  assign bus.o_busy    = busy_q;
  assign bus.o_lock    = lock_q;
  assign bus.o_err     = err_q;
endmodule

// File: doc/dly_lock_ctrl.md
Name: dly_lock_ctrl

Overview:
- Lock controller for the 8-bit delay select of the fine/coarse delay line. Bits [7:6] are the coarse code and bits [5:0] are the fine code.
- Closes the loop with an external phase detector. On each valid phase-detector sample it steps the code by ±1 LSB, then waits a settle period before sampling again.
- Declares lock after a set number of direction reversals (dithering around the target).
- Sits between the phase detector and the delay line's select input; software starts it and monitors it.

Parameters:
- CODE_W, 8, delay select width (2 coarse + 6 fine)
- INIT_CODE, 8'h00, code loaded on reset and on every start
- SETTLE_CYC, 16, clocks to wait after each code change before a phase-detector sample is accepted (range 1..255)
- LOCK_TOGGLES, 4, direction reversals required to declare lock (range 1..15)

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  asynchronous active-low reset
- i_start  in  1  single-cycle pulse; begins a calibration
- i_abort  in  1  single-cycle pulse; terminates calibration
- i_pd_vld  in  1  phase-detector sample strobe
- i_pd_early  in  1  qualified by i_pd_vld; 1 = delayed edge early (increase delay), 0 = late (decrease delay)
- o_dly_sel  out  CODE_W  registered delay select driven to the delay line
- o_busy  out  1  calibration in progress
- o_lock  out  1  lock achieved
- o_err  out  1  code saturated before lock

Behaviour:
- Reset (i_rstn=0, async): state IDLE, o_dly_sel=INIT_CODE, o_busy=0, o_lock=0, o_err=0, settle counter=0, toggle counter=0, previous-direction valid flag=0.
- All outputs are registered. Each transition below takes effect on the next i_clk edge.
- States: IDLE, SETTLE, SAMPLE, LOCKED, ERR.
- IDLE, LOCKED, ERR on i_start:
  - o_dly_sel=INIT_CODE; toggle counter and previous-direction valid flag cleared.
  - o_busy=1, o_lock=0, o_err=0; go to SETTLE.
  - o_busy rises 1 cycle after the i_start pulse.
- i_start while o_busy=1 is ignored.
- SETTLE: settle counter counts SETTLE_CYC clocks, then go to SAMPLE. i_pd_vld is ignored in SETTLE.
- SAMPLE: waits indefinitely for i_pd_vld. On i_pd_vld, let dir = i_pd_early:
  - If the previous-direction flag is valid and dir ≠ previous dir, increment the toggle counter. Store dir and set the flag.
  - If the toggle counter reaches LOCK_TOGGLES (checked after the increment): go to LOCKED with o_lock=1, o_busy=0, code unchanged.
  - Otherwise, if dir=1 and code=8'hFF, or dir=0 and code=8'h00: go to ERR with o_err=1, o_busy=0, code held.
  - Otherwise: code ± 1 (plain binary, so 8'h3F+1=8'h40 carries from fine to coarse); reload the settle counter; go to SETTLE.
- i_abort in any state: go to IDLE with o_busy=0 and o_lock=0; o_err and o_dly_sel hold. i_abort takes priority over i_start and over i_pd_vld in the same cycle.
- LOCKED and ERR hold all outputs until i_start or i_abort.
- Reset asserted mid-calibration returns immediately to the reset values.

Optional Feature:
- Macro: DLY_LOCK_CTRL_TRACK_EN.
- Defined: LOCKED keeps cycling through the SETTLE/SAMPLE sequence and steps the code ±1 per sample with o_lock held at 1 and o_busy held at 0. Saturation while tracking forces ERR (o_lock=0, o_err=1).
- Undefined: the code is frozen in LOCKED and i_pd_vld is ignored there.

Decomposition:
- Shared package dly_ctrl_pkg: state encoding constants (IDLE=0 … ERR=4), CODE_W, and the fine/coarse field widths (6/2) used by all delay-line blocks.
- One natural sub-module: dly_settle_cnt, a loadable down-counter with a done flag, instantiated for the settle timer.

Test Plan:
- Reset then start, i_pd_early held at 1 → code increments 00→01→02… with exactly SETTLE_CYC+1 clocks between steps (given i_pd_vld asserted every cycle); no sample is taken during SETTLE.
- Alternating early/late from code 8'h20 → code dithers 20/21; o_lock=1 after the 4th reversal; o_busy=0; code frozen.
- Early samples from 8'h3F → o_dly_sel=8'h40 (coarse carry); from 8'hFF early → o_err=1, code stays 8'hFF.
- i_abort during SETTLE with code 8'h05 → IDLE, o_busy=0, o_dly_sel=8'h05; i_start and i_abort in the same cycle → stays IDLE.
- i_rstn low mid-SAMPLE → o_dly_sel=INIT_CODE and all flags 0 asynchronously; a subsequent start works normally.
- With TRACK_EN defined, after lock an early sample moves code +1 while o_lock stays 1; without TRACK_EN the code is unchanged.
